// File: rtl/shift_arbiter_if.sv
// Request/response bundle for shift_arbiter: two request channels (packed per port)
// and one registered response channel.
interface shift_arbiter_if #(
  parameter int TAG_W = 4
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][31:0]      req_d;
  logic [1:0][4:0]       req_shamt;
  logic [1:0]            req_right;
  logic [1:0]            req_arith;
  logic [1:0][TAG_W-1:0] req_tag;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_data;
  logic                  resp_src;
  logic [TAG_W-1:0]      resp_tag;

  modport master (
    output req_valid, req_d, req_shamt, req_right, req_arith, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_src, resp_tag
  );

  modport slave (
    input  req_valid, req_d, req_shamt, req_right, req_arith, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_src, resp_tag
  );
endinterface

// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter sharing one 32-bit barrel shifter, 1-cycle registered response.
// Optional grant statistics: define SHIFT_ARB_STATS_EN to build grant_cnt0/grant_cnt1.

// Per-port ready/accept. ready looks only at the other port's valid and the
// round-robin pointer, so a requester never sees ready react to its own valid.
module shift_arbiter_port (
  input  logic slot_free,
  input  logic valid,
  input  logic other_valid,
  input  logic tie_win,
  output logic ready,
  output logic accept
);
  assign ready  = slot_free & (~other_valid | tie_win);
  assign accept = valid & ready;
endmodule

module shift_arbiter #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SHIFT_ARB_STATS_EN
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
`endif
  shift_arbiter_if.slave   bus
);
  localparam int NUM_PORTS = 2;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("shift_arbiter: CNT_W must be at least 1");
  end

  function automatic logic [31:0] barrel(input logic [31:0] d, input logic [4:0] sh,
                                         input logic right, input logic arith);
    logic [31:0] r;
    if (!right)     r = d << sh;
    else if (arith) r = 32'($signed(d) >>> sh);
    else            r = d >> sh;
    return r;
  endfunction

  logic                  resp_valid_q;
  logic                  resp_src_q;
  logic [31:0]           resp_data_q;
  logic [TAG_W-1:0]      resp_tag_q;
  logic                  last_grant;

  logic                  slot_free;
  logic [NUM_PORTS-1:0]  slot_free_v;
  logic [NUM_PORTS-1:0]  other_valid;
  logic [NUM_PORTS-1:0]  tie_win;
  logic [NUM_PORTS-1:0]  ready;
  logic [NUM_PORTS-1:0]  accept;
  logic                  any_accept;
  logic                  sel;
  logic [31:0]           shifted;

  assign slot_free   = ~resp_valid_q | bus.resp_ready;
  assign slot_free_v = {NUM_PORTS{slot_free}};
  assign other_valid = {bus.req_valid[0], bus.req_valid[1]};
  // Port 0 wins a tie when port 1 went last, and vice versa.
  assign tie_win     = {~last_grant, last_grant};

  shift_arbiter_port u_port [NUM_PORTS-1:0] (
    .slot_free   (slot_free_v),
    .valid       (bus.req_valid),
    .other_valid (other_valid),
    .tie_win     (tie_win),
    .ready       (ready),
    .accept      (accept)
  );

  assign bus.req_ready = ready;
  assign any_accept    = |accept;
  assign sel           = accept[1];
  assign shifted       = barrel(bus.req_d[sel], bus.req_shamt[sel],
                                bus.req_right[sel], bus.req_arith[sel]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_src_q   <= 1'b0;
      resp_tag_q   <= '0;
      last_grant   <= 1'b1;
    end else if (any_accept) begin
      resp_valid_q <= 1'b1;
      resp_data_q  <= shifted;
      resp_src_q   <= sel;
      resp_tag_q   <= bus.req_tag[sel];
      last_grant   <= sel;
    end else if (bus.resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_src   = resp_src_q;
  assign bus.resp_tag   = resp_tag_q;

`ifdef SHIFT_ARB_STATS_EN
  logic [NUM_PORTS-1:0][CNT_W-1:0] cnt;

  // Saturating: stop at all-ones rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (accept[i] && cnt[i] != {CNT_W{1'b1}}) cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end

  assign grant_cnt0 = cnt[0];
  assign grant_cnt1 = cnt[1];
`endif
endmodule
